// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback stage and the long-latency unit (LLU).
// Pipeline writes win; LLU results wait in a 2-entry in-order FIFO and drain
// into idle port cycles. A starvation counter forces a one-cycle pipeline
// stall so that the FIFO head is written once it has been denied MAX_WAIT
// times. The write port outputs are registered.
// Optional build macro WB_PENDING_MASK_EN adds the llu_pending output: a
// per-register mask of the destinations buffered in the FIFO.
module wb_port_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_valid,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  output logic            pipe_stall,
  input  logic            llu_valid,
  output logic            llu_ready,
  input  logic [4:0]      llu_rd,
  input  logic [XLEN-1:0] llu_wd,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [31:0]     llu_pending
`endif
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t state;
  logic [3:0] wait_cnt;

  // FIFO storage: slot 0 is always the head, entries shift down on dequeue
  logic [1:0]                 fifo_cnt;
  logic [1:0][4:0]            fifo_rd;
  logic [1:0][XLEN-1:0]       fifo_wd;

  logic [1:0]                 fifo_cnt_n;
  logic [1:0][4:0]            fifo_rd_n;
  logic [1:0][XLEN-1:0]       fifo_wd_n;

  logic fifo_empty;
  logic pipe_req;
  logic grant_pipe;
  logic grant_fifo;
  logic enq;
  logic deq;

  // Grant decision from registered state plus the current requests
  always_comb begin
    pipe_stall = (state == ST_FORCE);
    llu_ready  = (fifo_cnt != 2'd2);
    fifo_empty = (fifo_cnt == 2'd0);
    // x0 writes and writes presented during a stall are not requests
    pipe_req   = pipe_valid && (pipe_rd != '0) && !pipe_stall;
    grant_fifo = pipe_stall || (!pipe_req && !fifo_empty);
    grant_pipe = pipe_req;
    // x0 LLU results are accepted but dropped
    enq        = llu_valid && llu_ready && (llu_rd != '0);
    deq        = grant_fifo;
  end

  // Next FIFO contents; enqueue and dequeue may coincide when not full
  always_comb begin
    fifo_cnt_n = fifo_cnt;
    fifo_rd_n  = fifo_rd;
    fifo_wd_n  = fifo_wd;
    unique case ({enq, deq})
      2'b10: begin
        if (fifo_cnt == 2'd0) begin
          fifo_rd_n[0] = llu_rd;
          fifo_wd_n[0] = llu_wd;
        end else begin
          fifo_rd_n[1] = llu_rd;
          fifo_wd_n[1] = llu_wd;
        end
        fifo_cnt_n = fifo_cnt + 2'd1;
      end
      2'b01: begin
        fifo_rd_n[0] = fifo_rd[1];
        fifo_wd_n[0] = fifo_wd[1];
        fifo_cnt_n   = fifo_cnt - 2'd1;
      end
      2'b11: begin
        // Not full and not empty, so exactly one entry: the new one becomes head
        fifo_rd_n[0] = llu_rd;
        fifo_wd_n[0] = llu_wd;
      end
      default: begin
        fifo_cnt_n = fifo_cnt;
      end
    endcase
  end

  // FIFO state register
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_cnt <= '0;
      fifo_rd  <= '0;
      fifo_wd  <= '0;
    end else begin
      fifo_cnt <= fifo_cnt_n;
      fifo_rd  <= fifo_rd_n;
      fifo_wd  <= fifo_wd_n;
    end
  end

  // Starvation FSM: counts denials of the FIFO head and forces a drain
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          wait_cnt <= '0;
          if (fifo_cnt_n != 2'd0) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fifo_cnt_n == 2'd0) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (grant_fifo) begin
            wait_cnt <= '0;
          end else if (wait_cnt == MAX_CNT - 4'd1) begin
            // MAX_WAIT-th denial: the counter saturates and the next cycle stalls
            state    <= ST_FORCE;
            wait_cnt <= MAX_CNT;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_FORCE: begin
          wait_cnt <= '0;
          state    <= (fifo_cnt_n != 2'd0) ? ST_WAIT : ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (grant_pipe) begin
      rf_we <= 1'b1;
      rf_wa <= pipe_rd;
      rf_wd <= pipe_wd;
    end else if (grant_fifo) begin
      rf_we <= 1'b1;
      rf_wa <= fifo_rd[0];
      rf_wd <= fifo_wd[0];
    end else begin
      rf_we <= 1'b0;
    end
  end

`ifdef WB_PENDING_MASK_EN
  logic [31:0] pending_n;

  // Mask of destinations held in the FIFO after this edge
  always_comb begin
    pending_n = '0;
    if (fifo_cnt_n != 2'd0) pending_n[fifo_rd_n[0]] = 1'b1;
    if (fifo_cnt_n == 2'd2) pending_n[fifo_rd_n[1]] = 1'b1;
    pending_n[0] = 1'b0;
  end

  // Pending mask register, updated on the same edge as the FIFO
  always_ff @(posedge clk) begin
    if (reset) llu_pending <= '0;
    else       llu_pending <= pending_n;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed tests for wb_port_arbiter (XLEN=32, MAX_WAIT=4).
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        pipe_stall;
  logic        llu_valid;
  logic        llu_ready;
  logic [4:0]  llu_rd;
  logic [31:0] llu_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
`ifdef WB_PENDING_MASK_EN
  logic [31:0] llu_pending;
`endif

  int total;
  int passed;

  wb_port_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_wd    (pipe_wd),
    .pipe_stall (pipe_stall),
    .llu_valid  (llu_valid),
    .llu_ready  (llu_ready),
    .llu_rd     (llu_rd),
    .llu_wd     (llu_wd),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd)
`ifdef WB_PENDING_MASK_EN
    ,
    .llu_pending(llu_pending)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [37:0] port;
    reset = 1'b1;
    tick();
    tick();
    port = {rf_we, rf_wa, rf_wd};
    total++;
    if (port !== 38'd0) $display("FAIL reset_port: got %h want 0", port);
    else passed++;
    total++;
    if ({llu_ready, pipe_stall} !== 2'b10) $display("FAIL reset_ctl: got %b want 10", {llu_ready, pipe_stall});
    else passed++;
    reset = 1'b0;
    // Fill the FIFO while the pipeline keeps the port busy
    pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_wd = 32'h1;
    llu_valid = 1'b1; llu_rd = 5'd4; llu_wd = 32'h44;
    tick();
    llu_rd = 5'd6; llu_wd = 32'h66;
    tick();
    total++;
    if (llu_ready !== 1'b0) $display("FAIL reset_fill_full: got %b want 0", llu_ready);
    else passed++;
    reset = 1'b1; pipe_valid = 1'b0; llu_valid = 1'b0;
    tick();
    tick();
    total++;
    if ({rf_we, llu_ready, pipe_stall} !== 3'b010) $display("FAIL reset_mid: got %b want 010", {rf_we, llu_ready, pipe_stall});
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (rf_we !== 1'b0) $display("FAIL reset_no_write[%0d]: got %b want 0", i, rf_we);
      else passed++;
    end
  endtask

  task automatic test_idle_llu;
    llu_valid = 1'b1; llu_rd = 5'd5; llu_wd = 32'hDEADBEEF;
    tick();
    llu_valid = 1'b0;
    total++;
    if (rf_we !== 1'b0) $display("FAIL idle_llu_early: got %b want 0", rf_we);
    else passed++;
    tick();
    total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL idle_llu_write: got %b/%0d/%h want 1/5/deadbeef", rf_we, rf_wa, rf_wd);
    else passed++;
    tick();
    total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b0, 5'd5, 32'hDEADBEEF})
      $display("FAIL idle_llu_hold: got %b/%0d/%h want 0/5/deadbeef", rf_we, rf_wa, rf_wd);
    else passed++;
  endtask

  task automatic test_priority;
    llu_valid = 1'b1; llu_rd = 5'd7; llu_wd = 32'h77;
    tick();
    llu_valid = 1'b0;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h11;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if ({rf_we, rf_wa, rf_wd, pipe_stall} !== {1'b1, 5'd3, 32'h11, (i == 3)})
        $display("FAIL prio_pipe[%0d]: got %b/%0d/%h stall=%b want 1/3/11 stall=%b",
                 i, rf_we, rf_wa, rf_wd, pipe_stall, (i == 3));
      else passed++;
    end
    tick();
    total++;
    if ({rf_we, rf_wa, rf_wd, pipe_stall} !== {1'b1, 5'd7, 32'h77, 1'b0})
      $display("FAIL prio_force: got %b/%0d/%h stall=%b want 1/7/77 stall=0", rf_we, rf_wa, rf_wd, pipe_stall);
    else passed++;
    tick();
    total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h11})
      $display("FAIL prio_resume: got %b/%0d/%h want 1/3/11", rf_we, rf_wa, rf_wd);
    else passed++;
    pipe_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure;
    pipe_valid = 1'b1; pipe_rd = 5'd10; pipe_wd = 32'hAA;
    llu_valid = 1'b1; llu_rd = 5'd1; llu_wd = 32'h101;
    tick();
    total++;
    if (llu_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", llu_ready);
    else passed++;
    llu_rd = 5'd2; llu_wd = 32'h102;
    tick();
    total++;
    if (llu_ready !== 1'b0) $display("FAIL bp_full: got %b want 0", llu_ready);
    else passed++;
    llu_rd = 5'd3; llu_wd = 32'h103;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({llu_ready, pipe_stall, rf_wa} !== {1'b0, (i == 2), 5'd10})
        $display("FAIL bp_hold[%0d]: got ready=%b stall=%b wa=%0d want 0/%b/10",
                 i, llu_ready, pipe_stall, rf_wa, (i == 2));
      else passed++;
    end
    tick();
    total++;
    if ({rf_we, rf_wa, rf_wd, llu_ready} !== {1'b1, 5'd1, 32'h101, 1'b1})
      $display("FAIL bp_first: got %b/%0d/%h ready=%b want 1/1/101 ready=1", rf_we, rf_wa, rf_wd, llu_ready);
    else passed++;
    pipe_valid = 1'b0;
    tick();
    llu_valid = 1'b0;
    total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd2, 32'h102})
      $display("FAIL bp_second: got %b/%0d/%h want 1/2/102", rf_we, rf_wa, rf_wd);
    else passed++;
    tick();
    total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h103})
      $display("FAIL bp_third: got %b/%0d/%h want 1/3/103", rf_we, rf_wa, rf_wd);
    else passed++;
    tick();
    total++;
    if (rf_we !== 1'b0) $display("FAIL bp_drained: got %b want 0", rf_we);
    else passed++;
  endtask

  task automatic test_x0;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h33;
    llu_valid = 1'b1; llu_rd = 5'd12; llu_wd = 32'hC;
    tick();
    llu_valid = 1'b0;
    pipe_rd = 5'd0; pipe_wd = 32'h99;
    total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd3, 32'h33})
      $display("FAIL x0_pipe: got %b/%0d/%h want 1/3/33", rf_we, rf_wa, rf_wd);
    else passed++;
    tick();
    total++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 5'd12, 32'hC})
      $display("FAIL x0_pipe_drain: got %b/%0d/%h want 1/12/c", rf_we, rf_wa, rf_wd);
    else passed++;
    pipe_valid = 1'b0;
    llu_valid = 1'b1; llu_rd = 5'd0; llu_wd = 32'h55;
    total++;
    if (llu_ready !== 1'b1) $display("FAIL x0_llu_ready: got %b want 1", llu_ready);
    else passed++;
    tick();
    llu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rf_we, llu_ready, pipe_stall} !== 3'b010)
        $display("FAIL x0_llu_drop[%0d]: got %b want 010", i, {rf_we, llu_ready, pipe_stall});
      else passed++;
      tick();
    end
  endtask

`ifdef WB_PENDING_MASK_EN
  task automatic test_pending;
    pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h33;
    llu_valid = 1'b1; llu_rd = 5'd9; llu_wd = 32'h1;
    tick();
    total++;
    if (llu_pending !== 32'h0000_0200) $display("FAIL pend_one: got %h want 00000200", llu_pending);
    else passed++;
    llu_wd = 32'h2;
    tick();
    llu_valid = 1'b0; pipe_valid = 1'b0;
    total++;
    if (llu_pending !== 32'h0000_0200) $display("FAIL pend_two: got %h want 00000200", llu_pending);
    else passed++;
    tick();
    total++;
    if ({rf_wa, rf_wd, llu_pending} !== {5'd9, 32'h1, 32'h0000_0200})
      $display("FAIL pend_after_first: got %0d/%h/%h want 9/1/00000200", rf_wa, rf_wd, llu_pending);
    else passed++;
    tick();
    total++;
    if ({rf_wa, rf_wd, llu_pending} !== {5'd9, 32'h2, 32'h0})
      $display("FAIL pend_cleared: got %0d/%h/%h want 9/2/0", rf_wa, rf_wd, llu_pending);
    else passed++;
    tick();
  endtask
`endif

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    pipe_valid = 1'b0; pipe_rd = '0; pipe_wd = '0;
    llu_valid = 1'b0; llu_rd = '0; llu_wd = '0;
    test_reset();
    test_idle_llu();
    test_priority();
    test_backpressure();
    test_x0();
`ifdef WB_PENDING_MASK_EN
    test_pending();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
